// File: rtl/dist_search_pkg.sv
// Shared types and defaults for the distance-search sequencer.
// Optional watchdog feature is enabled with DIST_SEARCH_TIMEOUT_EN.
package dist_search_pkg;

  localparam int IDX_W_DEF  = 10;
  localparam int DIST_W_DEF = 38;

  localparam logic [DIST_W_DEF-1:0] DIST_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EVAL  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dist_best_tracker.sv
// Registered running minimum of candidate distances with its index.
// 'update' keeps a strictly smaller distance; 'load' takes the candidate unconditionally.
module dist_best_tracker #(
  parameter int IDX_W  = 10,
  parameter int DIST_W = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              update,
  input  logic              load,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic [DIST_W-1:0] cand_dist,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DIST_W-1:0] best_dist
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      best_dist <= '1;
      best_idx  <= '0;
    end else if (load || (update && (cand_dist < best_dist))) begin
      best_dist <= cand_dist;
      best_idx  <= cand_idx;
    end
  end

endmodule

// File: rtl/dist_search_ctrl.sv
// Sweeps candidate matrices through dist_calc, tracking the minimum distance with early exit.
// Define DIST_SEARCH_TIMEOUT_EN to add a WAIT watchdog and the err output.
module dist_search_ctrl
  import dist_search_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DIST_W  = DIST_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_cands,
  input  logic [DIST_W-1:0] threshold,
  output logic              cand_rd,
  output logic [IDX_W-1:0]  cand_addr,
  output logic              calc_ready,
  input  logic              calc_finished,
  input  logic [DIST_W-1:0] calc_dist2,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DIST_W-1:0] best_dist,
`ifdef DIST_SEARCH_TIMEOUT_EN
  output logic              err,
`endif
  output state_t            state_dbg
);

  // Handshake: cand_rd requests ROM data that is valid on the next cycle; calc_ready is a
  // single-cycle pulse and calc_finished/calc_dist2 are only honoured while in WAIT.
  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    n_lat;
  logic [DIST_W-1:0]   thr_lat;
  logic                sample;
  logic                hit;
  logic                trk_clear;

`ifdef DIST_SEARCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign state_dbg = state;
  assign sample    = (state == WAIT) && calc_finished;
  assign hit       = (calc_dist2 <= thr_lat);
  assign trk_clear = (state == IDLE) && start;

  dist_best_tracker #(
    .IDX_W  (IDX_W),
    .DIST_W (DIST_W)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (trk_clear),
    .update    (sample),
    .load      (sample && hit),
    .cand_idx  (idx),
    .cand_dist (calc_dist2),
    .best_idx  (best_idx),
    .best_dist (best_dist)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cand_rd    <= 1'b0;
      cand_addr  <= '0;
      calc_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      idx        <= '0;
      n_lat      <= '0;
      thr_lat    <= '0;
`ifdef DIST_SEARCH_TIMEOUT_EN
      err        <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            found   <= 1'b0;
            n_lat   <= num_cands;
            thr_lat <= threshold;
            idx     <= '0;
`ifdef DIST_SEARCH_TIMEOUT_EN
            err     <= 1'b0;
`endif
            if (num_cands == '0) begin
              state <= DONE;
            end else begin
              state     <= ISSUE;
              cand_rd   <= 1'b1;
              cand_addr <= '0;
            end
          end
        end
        ISSUE: begin
          cand_rd    <= 1'b0;
          calc_ready <= 1'b1;
          state      <= EVAL;
        end
        EVAL: begin
          calc_ready <= 1'b0;
          state      <= WAIT;
`ifdef DIST_SEARCH_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        WAIT: begin
          if (calc_finished) begin
            if (hit) begin
              found <= 1'b1;
              state <= DONE;
            end else if (idx == n_lat - IDX_W'(1)) begin
              state <= DONE;
            end else begin
              idx       <= idx + IDX_W'(1);
              cand_addr <= idx + IDX_W'(1);
              cand_rd   <= 1'b1;
              state     <= ISSUE;
            end
          end
`ifdef DIST_SEARCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_search_ctrl.sv
// Self-checking bench for dist_search_ctrl: directed table, corner sequences, random vs. model.
// Exercises the watchdog path when DIST_SEARCH_TIMEOUT_EN is defined.
module tb_dist_search_ctrl;
  import dist_search_pkg::*;

  localparam int IDX_W   = 10;
  localparam int DIST_W  = 38;
  localparam int TIMEOUT = 15;
  localparam int NT      = 6;

  logic              clk;
  logic              reset;
  logic              start;
  logic [IDX_W-1:0]  num_cands;
  logic [DIST_W-1:0] threshold;
  logic              cand_rd;
  logic [IDX_W-1:0]  cand_addr;
  logic              calc_ready;
  logic              calc_finished;
  logic [DIST_W-1:0] calc_dist2;
  logic              busy;
  logic              done;
  logic              found;
  logic [IDX_W-1:0]  best_idx;
  logic [DIST_W-1:0] best_dist;
  state_t            state_dbg;
`ifdef DIST_SEARCH_TIMEOUT_EN
  logic              err;
`endif

  dist_search_ctrl #(
    .IDX_W   (IDX_W),
    .DIST_W  (DIST_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_cands     (num_cands),
    .threshold     (threshold),
    .cand_rd       (cand_rd),
    .cand_addr     (cand_addr),
    .calc_ready    (calc_ready),
    .calc_finished (calc_finished),
    .calc_dist2    (calc_dist2),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .best_idx      (best_idx),
    .best_dist     (best_dist),
`ifdef DIST_SEARCH_TIMEOUT_EN
    .err           (err),
`endif
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- dist_calc + ROM responder and monitor ----------------
  logic [DIST_W-1:0] mem [16];
  int                block_idx = -1;
  int                rd_cnt    = 0;
  int                ready_cnt = 0;
  int                done_cnt  = 0;
  logic [IDX_W-1:0]  last_rd   = '0;
  logic              ready_seen = 1'b0;
  logic [IDX_W-1:0]  addr_seen  = '0;

  always begin
    @(posedge clk);
    #1;
    calc_finished = ready_seen && (int'(addr_seen) != block_idx);
    calc_dist2    = mem[addr_seen[3:0]];
    ready_seen    = calc_ready;
    addr_seen     = cand_addr;
    if (cand_rd) begin
      rd_cnt++;
      last_rd = cand_addr;
    end
    if (calc_ready) ready_cnt++;
    if (done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [IDX_W+DIST_W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan candidates in order; stop on first within threshold, else keep strict minimum.
  task automatic model(input int n, input logic [DIST_W-1:0] thr, output int e_idx,
                       output logic [DIST_W-1:0] e_dist, output bit e_found, output int e_eval);
    e_idx = 0; e_dist = '1; e_found = 0; e_eval = 0;
    for (int i = 0; i < n; i++) begin
      e_eval = i + 1;
      if (mem[i] <= thr) begin
        e_found = 1; e_dist = mem[i]; e_idx = i;
        break;
      end
      if (mem[i] < e_dist) begin
        e_dist = mem[i]; e_idx = i;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_search(input int n, input logic [DIST_W-1:0] thr, output int lat);
    @(negedge clk);
    start     = 1'b1;
    num_cands = IDX_W'(n);
    threshold = thr;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_after_start", busy, 1);
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  typedef struct {
    int                n;
    logic [DIST_W-1:0] thr;
    int                e_idx;
    logic [DIST_W-1:0] e_dist;
    bit                e_found;
    int                e_eval;
  } vec_t;

  vec_t              tab   [NT];
  logic [DIST_W-1:0] tab_d [NT][8];

  task automatic apply_case(input int k);
    int lat, r0, d0;
    for (int i = 0; i < 8; i++) mem[i] = tab_d[k][i];
    r0 = ready_cnt;
    d0 = rd_cnt;
    run_search(tab[k].n, tab[k].thr, lat);
    check($sformatf("case%0d_best_idx", k), best_idx, tab[k].e_idx);
    check($sformatf("case%0d_best_dist", k), best_dist, tab[k].e_dist);
    check($sformatf("case%0d_found", k), found, tab[k].e_found);
    check($sformatf("case%0d_latency", k), lat, 3 * tab[k].e_eval + 2);
    check($sformatf("case%0d_ready_pulses", k), ready_cnt - r0, tab[k].e_eval);
    check($sformatf("case%0d_rom_reads", k), rd_cnt - d0, tab[k].e_eval);
    check($sformatf("case%0d_last_addr", k), last_rd, tab[k].e_eval - 1);
  endtask

  initial begin
    int lat, r0, d0, n, e_idx, e_eval, wcnt;
    logic [DIST_W-1:0] thr, e_dist;
    bit e_found;
    logic [IDX_W+DIST_W:0] exp_v;

    tab[0] = '{n: 4, thr: 0,  e_idx: 1, e_dist: 120,      e_found: 0, e_eval: 4};
    tab[1] = '{n: 5, thr: 10, e_idx: 2, e_dist: 10,       e_found: 1, e_eval: 3};
    tab[2] = '{n: 1, thr: 0,  e_idx: 0, e_dist: 77,       e_found: 0, e_eval: 1};
    tab[3] = '{n: 3, thr: 5,  e_idx: 0, e_dist: 5,        e_found: 1, e_eval: 1};
    tab[4] = '{n: 3, thr: 0,  e_idx: 0, e_dist: DIST_MAX, e_found: 0, e_eval: 3};
    tab[5] = '{n: 4, thr: 0,  e_idx: 0, e_dist: 9,        e_found: 0, e_eval: 4};
    tab_d[0] = '{500, 120, 300, 120, 0, 0, 0, 0};
    tab_d[1] = '{900, 40, 10, 7, 3, 0, 0, 0};
    tab_d[2] = '{77, 0, 0, 0, 0, 0, 0, 0};
    tab_d[3] = '{5, 1, 0, 0, 0, 0, 0, 0};
    tab_d[4] = '{DIST_MAX, DIST_MAX, DIST_MAX, 0, 0, 0, 0, 0};
    tab_d[5] = '{9, 9, 9, 9, 0, 0, 0, 0};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    start = 1'b0; num_cands = '0; threshold = '0;
    calc_finished = 1'b0; calc_dist2 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_cand_rd", cand_rd, 0);
    check("rst_calc_ready", calc_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_cand_addr", cand_addr, 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_dist", best_dist, DIST_MAX);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b0;

    for (int k = 0; k < NT; k++) apply_case(k);

    // Empty search after a populated one must restore the initial best values.
    r0 = ready_cnt;
    run_search(0, 0, lat);
    check("empty_latency", lat, 2);
    check("empty_best_dist", best_dist, DIST_MAX);
    check("empty_best_idx", best_idx, 0);
    check("empty_found", found, 0);
    check("empty_no_ready", ready_cnt - r0, 0);

    // Reset while waiting on candidate 2 of 6.
    for (int i = 0; i < 6; i++) mem[i] = DIST_W'(100 * (6 - i));
    @(negedge clk);
    start = 1'b1; num_cands = 6; threshold = 0;
    @(negedge clk);
    start = 1'b0;
    wcnt = 0;
    while (!(state_dbg == WAIT && cand_addr == 2) && wcnt < 50) begin
      @(negedge clk);
      wcnt++;
    end
    check("midrst_reached_wait2", wcnt < 50, 1);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cand_rd", cand_rd, 0);
    check("midrst_calc_ready", calc_ready, 0);
    check("midrst_cand_addr", cand_addr, 0);
    check("midrst_best_idx", best_idx, 0);
    check("midrst_best_dist", best_dist, DIST_MAX);
    check("midrst_found", found, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    apply_case(0);

    // start held high through a whole 3-candidate search.
    mem[0] = 30; mem[1] = 20; mem[2] = 10;
    @(negedge clk);
    r0 = ready_cnt;
    d0 = done_cnt;
    start = 1'b1; num_cands = 3; threshold = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 200);
    start = 1'b0;
    check("held_latency", lat, 11);
    repeat (10) @(negedge clk);
    check("held_one_done", done_cnt - d0, 1);
    check("held_ready_pulses", ready_cnt - r0, 3);
    check("held_idle_busy", busy, 0);
    check("held_best_idx", best_idx, 2);
    check("held_best_dist", best_dist, 10);

    // Randomized searches against the reference model.
    for (int t = 0; t < 25; t++) begin
      n   = $urandom_range(1, 16);
      thr = DIST_W'($urandom_range(0, 150));
      for (int i = 0; i < 16; i++) mem[i] = DIST_W'($urandom_range(0, 2000));
      model(n, thr, e_idx, e_dist, e_found, e_eval);
      exp_q.push_back({e_found, IDX_W'(e_idx), e_dist});
      run_search(n, thr, lat);
      exp_v = exp_q.pop_front();
      check($sformatf("rand%0d_result", t), {found, best_idx, best_dist}, exp_v);
      check($sformatf("rand%0d_latency", t), lat, 3 * e_eval + 2);
    end

`ifdef DIST_SEARCH_TIMEOUT_EN
    // Withhold calc_finished on candidate 1 to trip the watchdog.
    mem[0] = 50; mem[1] = 60; mem[2] = 70;
    block_idx = 1;
    run_search(3, 0, lat);
    check("wdog_err", err, 1);
    check("wdog_latency", lat, 3 + 2 + TIMEOUT + 2);
    check("wdog_best_idx", best_idx, 0);
    check("wdog_best_dist", best_dist, 50);
    check("wdog_found", found, 0);
    block_idx = -1;
    run_search(3, 0, lat);
    check("wdog_err_cleared", err, 0);
    check("wdog_after_best", best_dist, 50);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist_search_ctrl.md
Name: dist_search_ctrl

Overview:
- Sequencer that sweeps a candidate-matrix library through the dist_calc datapath against a fixed target matrix.
- Tracks the minimum squared distance and its index, and terminates early when a candidate falls within a threshold.
- Sits between the gate-library ROM, whose read data drives dist_calc's mtx_b, and the top-level compiler control.
- The target matrix (mtx_a) is held externally; this block only sequences.

Parameters:
- IDX_W, 10, width of candidate index / ROM address.
- DIST_W, 38, width of dist2 from dist_calc.
- TIMEOUT, 15, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a search; sampled in IDLE only.
- num_cands  in  IDX_W  number of candidates to evaluate; latched on start.
- threshold  in  DIST_W  early-exit limit; latched on start.
- cand_rd  out  1  ROM read enable.
- cand_addr  out  IDX_W  ROM address; data is valid the cycle after cand_rd.
- calc_ready  out  1  one-cycle pulse to dist_calc ready.
- calc_finished  in  1  from dist_calc finished.
- calc_dist2  in  DIST_W  from dist_calc dist2.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- found  out  1  search ended on a threshold hit.
- best_idx  out  IDX_W  index of the minimum distance.
- best_dist  out  DIST_W  minimum distance seen.

Behaviour:
- Reset values: state IDLE; cand_rd, calc_ready, busy, done, found all 0; cand_addr 0; best_idx 0; best_dist all-ones. A reset mid-search aborts immediately with no done pulse.
- IDLE:
  - start=1 and num_cands=0 -> DONE; best_* are reset to their initial values, found=0.
  - start=1 otherwise -> ISSUE; latch num_cands and threshold; idx=0; best_dist=all-ones; best_idx=0; found=0.
  - start while not in IDLE is ignored.
- ISSUE: cand_rd=1, cand_addr=idx -> EVAL.
- EVAL: ROM data is valid; calc_ready=1 -> WAIT. cand_addr holds idx so the ROM output stays stable.
- WAIT: on calc_finished=1, sample calc_dist2 (unsigned).
  - If calc_dist2 < best_dist: update best_dist and best_idx. The comparison is strict, so ties keep the lower index.
  - If calc_dist2 <= threshold: found=1 and best is updated regardless of the tie rule -> DONE.
  - Else if idx == num_cands-1 -> DONE.
  - Else idx++ -> ISSUE.
  - While calc_finished=0, remain in WAIT.
- DONE: done=1 for one cycle, busy=0 -> IDLE. best_*/found hold until the next accepted start.
- Throughput: 3 cycles per candidate, since dist_calc asserts finished one cycle after ready.
- calc_finished seen outside WAIT is ignored.
- idx never wraps: num_cands=2^IDX_W-1 is the maximum count. 0 means an empty search.

Optional Feature:
- Macro: DIST_SEARCH_TIMEOUT_EN.
- Defined: a counter runs in WAIT. Reaching TIMEOUT cycles without calc_finished -> DONE with output err=1 (extra 1-bit port, reset 0, cleared on start). best_* keep the values accumulated so far.
- Undefined: no counter and no err port; WAIT waits indefinitely.

Decomposition:
- Package dist_search_pkg:
  - state enum {IDLE, ISSUE, EVAL, WAIT, DONE}.
  - IDX_W and DIST_W defaults.
  - DIST_MAX constant (all-ones).
- One natural sub-module, dist_best_tracker: registered min-compare holding best_dist/best_idx, with clear and update strobes.

Test Plan:
- num_cands=4, dist2 sequence {500,120,300,120}, threshold=0 -> done after 12+ cycles, best_idx=1, best_dist=120, found=0.
- num_cands=5, dist2 {900,40,10,7,3}, threshold=10 -> stops after idx 2, best_idx=2, best_dist=10, found=1; cand_addr never reaches 3.
- num_cands=0, start -> done pulses 2 cycles later, best_dist=all-ones, best_idx=0, found=0; calc_ready never asserted.
- Reset asserted in WAIT at candidate 2 of 6 -> next cycle all outputs at reset values, no done; a new start then runs a full search correctly.
- start held high through an entire 3-candidate search -> exactly one search, exactly one done pulse; restarts only when start is seen in IDLE.
- With DIST_SEARCH_TIMEOUT_EN and TIMEOUT=15, calc_finished withheld on candidate 1 -> done and err=1 after 15 WAIT cycles, best_idx=0 retained.
